// File: rtl/pbkdf2_dispatch.sv
// Fans PBKDF2 jobs from a one-entry buffer out to a bank of cores and merges their
// hashes onto one stream, in either job-acceptance order or completion order.
module pbkdf2_dispatch #(
   parameter int num_cores_p      = 4,
   parameter int in_order_p       = 1,
   parameter int iters_width_p    = 32,
   parameter int pass_width_p     = 512,
   parameter int salt_width_p     = 512,
   parameter int salt_len_width_p = 6,
   parameter int hash_width_p     = 256,
   localparam int id_w            = (num_cores_p > 1) ? $clog2(num_cores_p) : 1,
   localparam int cnt_w           = $clog2(num_cores_p + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [iters_width_p-1:0]              iters_i,
   input  logic [pass_width_p-1:0]               pass_i,
   input  logic [salt_width_p-1:0]               salt_i,
   input  logic [salt_len_width_p-1:0]           salt_len_i,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [hash_width_p-1:0]               hash_o,
   output logic [id_w-1:0]                       core_id_o,
   output logic [cnt_w-1:0]                      in_flight_o,
   output logic [num_cores_p-1:0]                core_in_valid_o,
   input  logic [num_cores_p-1:0]                core_in_ready_i,
   output logic [iters_width_p-1:0]              core_iters_o,
   output logic [pass_width_p-1:0]               core_pass_o,
   output logic [salt_width_p-1:0]               core_salt_o,
   output logic [salt_len_width_p-1:0]           core_salt_len_o,
   input  logic [num_cores_p-1:0]                core_out_valid_i,
   output logic [num_cores_p-1:0]                core_out_ready_o,
   input  logic [num_cores_p*hash_width_p-1:0]   core_hash_i
);

   logic                   job_v_r;
   logic [num_cores_p-1:0] busy_r;
   logic [id_w-1:0]        rr_ptr_r, out_rr_r;
   logic [id_w-1:0]        fifo_mem [num_cores_p];
   logic [id_w-1:0]        wr_ptr_r, rd_ptr_r;
   logic [cnt_w-1:0]       count_r;

   logic [id_w-1:0]        sel, rr_head, fifo_head, head;
   logic                   sel_found, rr_found, head_valid;
   logic                   dispatch_fire, out_fire, accept;

   function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] p);
      return (p == id_w'(num_cores_p - 1)) ? '0 : p + id_w'(1);
   endfunction

   function automatic logic [id_w-1:0] scan_idx(input logic [id_w-1:0] base, input int off);
      return id_w'((int'(base) + off) % num_cores_p);
   endfunction

   // Scanning downward lets the lowest round-robin offset win without an early exit.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      rr_head   = '0;
      rr_found  = 1'b0;
      for (int i = num_cores_p - 1; i >= 0; i--) begin
         if (~busy_r[scan_idx(rr_ptr_r, i)] & core_in_ready_i[scan_idx(rr_ptr_r, i)]) begin
            sel       = scan_idx(rr_ptr_r, i);
            sel_found = 1'b1;
         end
         if (busy_r[scan_idx(out_rr_r, i)] & core_out_valid_i[scan_idx(out_rr_r, i)]) begin
            rr_head  = scan_idx(out_rr_r, i);
            rr_found = 1'b1;
         end
      end
   end

   assign fifo_head  = fifo_mem[rd_ptr_r];
   assign head       = (in_order_p != 0) ? fifo_head : rr_head;
   assign head_valid = (in_order_p != 0) ? ((count_r != '0) & core_out_valid_i[fifo_head])
                                         : rr_found;

   assign dispatch_fire = ~rst_i & job_v_r & sel_found;
   assign in_ready      = ~rst_i & (~job_v_r | dispatch_fire);
   assign accept        = in_valid & in_ready;
   assign out_valid     = ~rst_i & head_valid;
   assign out_fire      = out_valid & out_ready;

   assign core_in_valid_o  = dispatch_fire ? (num_cores_p'(1) << sel) : '0;
   assign core_out_ready_o = out_fire ? (num_cores_p'(1) << head) : '0;
   assign hash_o           = out_valid ? core_hash_i[head*hash_width_p +: hash_width_p] : '0;
   assign core_id_o        = out_valid ? head : '0;

   always_comb begin
      in_flight_o = '0;
      for (int i = 0; i < num_cores_p; i++) begin
         in_flight_o = in_flight_o + cnt_w'(busy_r[i]);
      end
      if (rst_i) in_flight_o = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         job_v_r         <= 1'b0;
         busy_r          <= '0;
         rr_ptr_r        <= '0;
         out_rr_r        <= '0;
         wr_ptr_r        <= '0;
         rd_ptr_r        <= '0;
         count_r         <= '0;
         core_iters_o    <= '0;
         core_pass_o     <= '0;
         core_salt_o     <= '0;
         core_salt_len_o <= '0;
      end else begin
         if (accept) begin
            core_iters_o    <= iters_i;
            core_pass_o     <= pass_i;
            core_salt_o     <= salt_i;
            core_salt_len_o <= salt_len_i;
         end
         job_v_r <= accept | (job_v_r & ~dispatch_fire);
         // Set and clear masks never overlap: dispatch needs an idle core, return a busy one.
         busy_r  <= (busy_r | core_in_valid_o) & ~core_out_ready_o;
         count_r <= count_r + cnt_w'(dispatch_fire) - cnt_w'(out_fire);
         if (dispatch_fire) begin
            rr_ptr_r <= wrap_inc(sel);
            wr_ptr_r <= wrap_inc(wr_ptr_r);
         end
         if (out_fire) begin
            rd_ptr_r <= wrap_inc(rd_ptr_r);
            if (in_order_p == 0) out_rr_r <= wrap_inc(head);
         end
      end
   end

   // NOTE: the order FIFO storage is not reset; count_r alone says which entries are live.
   always_ff @(posedge clk_i) begin
      if (dispatch_fire) fifo_mem[wr_ptr_r] <= sel;
   end

endmodule

// File: doc/pbkdf2_dispatch.md
Name: pbkdf2_dispatch

Overview:
Job dispatcher that fans PBKDF2 requests out to num_cores_p independent pbkdf2 cores and collects their 256-bit hashes onto one output stream. It sits between the host/trace-replay job stream and a bank of cores, and raises throughput without changing the single-core job format. It has two return modes: in-order (results come back in job-acceptance order) and completion-order (results come back as soon as any core finishes).

Parameters:
num_cores_p, 4, number of attached pbkdf2 cores (>=1).
in_order_p, 1, 1 = results in acceptance order; 0 = completion order.
iters_width_p, 32, iteration-count width.
pass_width_p, 512, password field width.
salt_width_p, 512, salt field width.
salt_len_width_p, 6, salt length field width.
hash_width_p, 256, result width.
(id_w = max(1, clog2(num_cores_p)))

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
in_valid  in  1  job valid.
in_ready  out  1  job buffer can accept.
iters_i / pass_i / salt_i / salt_len_i  in  per params  job fields.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
hash_o  out  hash_width_p  result hash.
core_id_o  out  id_w  core that produced the result.
in_flight_o  out  clog2(num_cores_p+1)  number of busy cores.
core_in_valid_o  out  num_cores_p  per-core job valid.
core_in_ready_i  in  num_cores_p  per-core job ready.
core_iters_o / core_pass_o / core_salt_o / core_salt_len_o  out  per params  buffered job, broadcast to all cores.
core_out_valid_i  in  num_cores_p  per-core result valid.
core_out_ready_o  out  num_cores_p  per-core result ready.
core_hash_i  in  num_cores_p*hash_width_p  core k result at bits [k*hash_width_p +: hash_width_p].

Behaviour:
- Reset (while rst_i=1 and on the following edge):
  - job_v_r=0, busy_r=0, rr_ptr_r=0, order FIFO empty, out_rr_r=0.
  - in_ready=0 while rst_i is high. All other outputs are 0.
  - Reset mid-job discards all in-flight state. Cores share rst_i.
- Job buffer:
  - One-entry register.
  - in_ready = ~rst_i & (~job_v_r | dispatch_fire).
  - Accept on in_valid & in_ready. Fields are latched and job_v_r=1 on the next edge.
  - Back-to-back accept and dispatch are allowed in the same cycle.
- Dispatch select:
  - sel = first index scanning rr_ptr_r, rr_ptr_r+1, … (mod num_cores_p) with ~busy_r[i] & core_in_ready_i[i].
  - core_in_valid_o is one-hot at sel when job_v_r, otherwise 0.
  - dispatch_fire = job_v_r & some core eligible.
  - On fire: busy_r[sel]<=1, rr_ptr_r<=(sel+1) mod num_cores_p, sel is pushed to the order FIFO, and job_v_r clears unless it is refilled in the same cycle.
  - No eligible core: job held, no state change.
- Order FIFO:
  - Depth num_cores_p. It can never overflow because pushes require an idle core.
  - Push and pop in the same cycle are legal.
- Return, in_order_p=1:
  - head = FIFO head.
  - out_valid = FIFO non-empty & core_out_valid_i[head].
  - core_out_ready_o = one-hot at head gated by out_ready & out_valid.
  - A finished non-head core waits (its valid stays asserted).
- Return, in_order_p=0:
  - head = first index from out_rr_r with busy_r[i] & core_out_valid_i[i].
  - On transfer, out_rr_r<=head+1 mod num_cores_p. The FIFO is unused.
- Result transfer:
  - On out_valid & out_ready: busy_r[head]<=0, FIFO pops (in-order mode).
  - hash_o/core_id_o are combinational from head and are held stable while out_valid & ~out_ready.
  - The freed core becomes eligible for dispatch on the next cycle, not the same cycle.
- core_out_valid_i from a core with busy_r=0 is ignored and never acknowledged.
- in_flight_o = popcount(busy_r).
- Latency through the block: 1 cycle accept→dispatch minimum; 0 cycles core result→out_valid.

Test Plan:
1. Reset with in_valid=1 held → in_ready=0, out_valid=0, core_in_valid_o=0 throughout reset. First accept occurs on the first cycle after rst_i falls.
2. Four jobs back-to-back (iters=1,2,3,4), all cores ready → dispatched to cores 0,1,2,3 on consecutive cycles. in_flight_o reaches 4. Fifth job is held with in_ready=0 after buffering.
3. in_order_p=1, core 2 finishes first, then cores 0,1,3 → out_valid stays 0 until core 0 is valid. Outputs are core_id_o=0,1,2,3 in that order, hashes matching each core.
4. in_order_p=0, same completion pattern → core_id_o order 2,0,1,3. Each busy bit clears on its transfer.
5. out_ready=0 for 5 cycles with result pending → hash_o/core_id_o stable and core_out_ready_o=0. Release → a single transfer and in_flight_o decrements by 1.
6. All cores busy, core 1 completes while a job is buffered → job dispatched to core 1 the cycle after the result transfer. rr_ptr_r=2 afterwards. Then assert rst_i mid-run → busy_r=0, FIFO empty, outputs zero.
